// File: rtl/bht_update_scheduler.sv
// Branch history table owner: post-reset init sweep, ROB training FIFO and conflict-aware drain.
// Define BHT_FWD_EN so that same-index drains forward to lookup and never stall.
module bht_update_scheduler #(
  parameter int         SIZE     = 9,
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] INIT_VAL = 2'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       lookup_valid,
  input  logic [31:0]                lookup_ins,
  output logic                       lookup_taken,
  input  logic                       train_valid,
  input  logic                       train_taken,
  input  logic [31:0]                train_code,
  output logic                       train_ready,
  output logic                       busy,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int AW      = $clog2(QDEPTH);
  localparam int QCW     = AW + 1;
  localparam int ENTRIES = 1 << SIZE;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [SIZE-1:0]   sweep_idx, sweep_next;
  logic              in_run;
  logic              sweep_we;

  logic [1:0]        bht [ENTRIES];
  logic [SIZE:0]     fifo_mem [QDEPTH];
  logic [AW-1:0]     head, tail;

  logic [SIZE-1:0]   lookup_idx;
  logic [SIZE-1:0]   train_idx;
  logic [SIZE-1:0]   head_idx;
  logic              head_taken;
  logic [1:0]        head_cnt;
  logic [1:0]        upd_cnt;
  logic [1:0]        lookup_cnt;
  logic              push, pop, stall;
  logic              unused_bits;

  assign lookup_idx = lookup_ins[5+SIZE:6];
  assign train_idx  = train_code[5+SIZE:6];
  assign unused_bits = ^{lookup_valid, lookup_ins[31:6+SIZE], lookup_ins[5:0],
                         train_code[31:6+SIZE], train_code[5:0]};

  // State register: rst always restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_next;
    end
  end

  always_comb begin
    state_next = state;
    sweep_next = sweep_idx;
    busy       = 1'b0;
    in_run     = 1'b0;
    sweep_we   = 1'b0;
    case (state)
      ST_INIT: begin
        busy = 1'b1;
        if (rdy) begin
          sweep_we   = 1'b1;
          sweep_next = sweep_idx + SIZE'(1);
          if (&sweep_idx) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        in_run = 1'b1;
      end
      default: begin
        state_next = ST_INIT;
        sweep_next = '0;
      end
    endcase
  end

  assign head_idx   = fifo_mem[head][SIZE:1];
  assign head_taken = fifo_mem[head][0];
  assign head_cnt   = bht[head_idx];
  assign lookup_cnt = bht[lookup_idx];

  always_comb begin
    upd_cnt = head_cnt;
    if (head_taken) begin
      if (head_cnt != 2'b11) upd_cnt = head_cnt + 2'd1;
    end else begin
      if (head_cnt != 2'b00) upd_cnt = head_cnt - 2'd1;
    end
  end

  assign train_ready = in_run && (q_count < QCW'(QDEPTH));
  assign push        = rdy && train_valid && train_ready;

`ifdef BHT_FWD_EN
  logic fwd_hit;
  assign stall        = 1'b0;
  assign pop          = rdy && in_run && (q_count != '0);
  assign fwd_hit      = pop && (lookup_idx == head_idx);
  assign lookup_taken = in_run && (fwd_hit ? upd_cnt[1] : lookup_cnt[1]);
`else
  // Fetch lookup wins a same-index collision; the drain waits a cycle.
  assign stall        = lookup_valid && (lookup_idx == head_idx);
  assign pop          = rdy && in_run && (q_count != '0) && !stall;
  assign lookup_taken = in_run && lookup_cnt[1];
`endif

  // Training FIFO storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= {train_idx, train_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + QCW'(1);
        2'b01:   q_count <= q_count - QCW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Single table write port, shared by the init sweep and the drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we)
        bht[sweep_idx] <= INIT_VAL;
      else if (pop)
        bht[head_idx] <= upd_cnt;
    end
  end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Self-checking bench for bht_update_scheduler (SIZE=9, QDEPTH=4, INIT_VAL=1); honours BHT_FWD_EN.
module tb_bht_update_scheduler;

  localparam int SIZE   = 9;
  localparam int QDEPTH = 4;
`ifdef BHT_FWD_EN
  localparam int QH = 1;
`else
  localparam int QH = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        lookup_valid;
  logic [31:0] lookup_ins;
  logic        lookup_taken;
  logic        train_valid, train_taken;
  logic [31:0] train_code;
  logic        train_ready, busy;
  logic [2:0]  q_count;

  int total  = 0;
  int passed = 0;

  bht_update_scheduler #(.SIZE(SIZE), .QDEPTH(QDEPTH), .INIT_VAL(2'd1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lookup_valid(lookup_valid), .lookup_ins(lookup_ins), .lookup_taken(lookup_taken),
    .train_valid(train_valid), .train_taken(train_taken), .train_code(train_code),
    .train_ready(train_ready), .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [8:0] tidx;
    logic       taken;
    logic [8:0] lidx;
    logic       exp;
  } vec_t;

  vec_t vecs[21];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic [31:0] makeIns(input logic [8:0] idx);
    logic [31:0] r;
    r       = $urandom;
    r[14:6] = idx;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] idx, input logic taken);
    train_valid = 1'b1;
    train_taken = taken;
    train_code  = makeIns(idx);
    tick();
    train_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (q_count != 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(q_count), 0);
  endtask

  task automatic waitSweep(input string name, input int expected_cycles);
    int n;
    n = 0;
    #1;
    while (busy && n < 2000) begin
      tick();
      #1;
      n++;
    end
    checkOutput(name, n, expected_cycles);
    checkOutput({name, "_ready"}, 32'(train_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit done;
    int expQ[13];
    int expR[13];
    int expL[13];

    vecs[0]  = '{1'b0, 9'd0,   1'b0, 9'd0,   1'b0};
    vecs[1]  = '{1'b0, 9'd0,   1'b0, 9'd511, 1'b0};
    vecs[2]  = '{1'b0, 9'd0,   1'b0, 9'd255, 1'b0};
    vecs[3]  = '{1'b1, 9'd5,   1'b1, 9'd5,   1'b1};
    vecs[4]  = '{1'b1, 9'd5,   1'b1, 9'd5,   1'b1};
    vecs[5]  = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b0};
    vecs[6]  = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b0};
    vecs[7]  = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b0};
    vecs[8]  = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b0};
    vecs[9]  = '{1'b1, 9'd7,   1'b1, 9'd7,   1'b0};
    vecs[10] = '{1'b1, 9'd7,   1'b1, 9'd7,   1'b1};
    vecs[11] = '{1'b1, 9'd7,   1'b1, 9'd7,   1'b1};
    vecs[12] = '{1'b1, 9'd7,   1'b1, 9'd7,   1'b1};
    vecs[13] = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b1};
    vecs[14] = '{1'b1, 9'd7,   1'b0, 9'd7,   1'b0};
    vecs[15] = '{1'b1, 9'd6,   1'b1, 9'd5,   1'b1};
    vecs[16] = '{1'b1, 9'd4,   1'b0, 9'd6,   1'b1};
    vecs[17] = '{1'b1, 9'd511, 1'b1, 9'd511, 1'b1};
    vecs[18] = '{1'b1, 9'd0,   1'b0, 9'd0,   1'b0};
    vecs[19] = '{1'b1, 9'd0,   1'b1, 9'd0,   1'b0};
    vecs[20] = '{1'b0, 9'd0,   1'b0, 9'd8,   1'b0};

`ifdef BHT_FWD_EN
    expQ = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    expR = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    expL = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    expQ = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    expR = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    expL = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif

    // Reset and a mid-sweep reset at idx 300
    rst = 1'b1; rdy = 1'b1; lookup_valid = 1'b0; lookup_ins = makeIns(9'd5);
    train_valid = 1'b0; train_taken = 1'b0; train_code = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 1);
    checkOutput("reset_ready", 32'(train_ready), 0);
    checkOutput("reset_qcount", 32'(q_count), 0);
    checkOutput("reset_lookup", 32'(lookup_taken), 0);

    train_valid = 1'b1;
    train_taken = 1'b1;
    train_code  = makeIns(9'd9);
    repeat (300) tick();
    lookup_ins = makeIns(9'd0);
    #1;
    checkOutput("sweep300_busy", 32'(busy), 1);
    checkOutput("sweep300_ready", 32'(train_ready), 0);
    checkOutput("sweep300_lookup", 32'(lookup_taken), 0);
    checkOutput("sweep300_qcount", 32'(q_count), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    train_valid = 1'b0;
    #1;
    checkOutput("rerst_busy", 32'(busy), 1);
    checkOutput("rerst_qcount", 32'(q_count), 0);

    // Sweep with rdy low for 10 cycles at idx 100: 512 + 10 busy cycles
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      rdy = !(c >= 100 && c < 110);
      #1;
      if (!busy) begin
        done = 1'b1;
        checkOutput("run_ready_same_cycle", 32'(train_ready), 1);
      end else begin
        n++;
        if (c == 105) begin
          checkOutput("init_ready_low", 32'(train_ready), 0);
          checkOutput("init_lookup_low", 32'(lookup_taken), 0);
        end
        tick();
      end
    end
    checkOutput("sweep_cycles", n, 522);
    checkOutput("post_init_qcount", 32'(q_count), 0);
    rdy = 1'b1;
    tick();

    // Table-driven training and lookup
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].push) applyStimulus(vecs[i].tidx, vecs[i].taken);
      waitDrain($sformatf("vec%0d_drain", i));
      lookup_ins = makeIns(vecs[i].lidx);
      #1;
      checkOutput($sformatf("vec%0d_lookup", i), 32'(lookup_taken), 32'(vecs[i].exp));
      tick();
    end

    // Back-to-back pushes with lookup held on the head index
    lookup_valid = 1'b1;
    lookup_ins   = makeIns(9'd20);
    for (int k = 0; k < 13; k++) begin
      train_valid = (k < 5);
      train_taken = 1'b1;
      train_code  = makeIns(9'd20);
      if (k >= 8) lookup_valid = 1'b0;
      #1;
      checkOutput($sformatf("conf%0d_qcount", k), 32'(q_count), expQ[k]);
      checkOutput($sformatf("conf%0d_ready", k), 32'(train_ready), expR[k]);
      checkOutput($sformatf("conf%0d_lookup", k), 32'(lookup_taken), expL[k]);
      tick();
    end
    train_valid = 1'b0;

    // rdy low for 10 cycles mid-drain
    lookup_valid = 1'b1;
    lookup_ins   = makeIns(9'd40);
    for (int k = 0; k < 3; k++) begin
      train_valid = 1'b1;
      train_taken = 1'b1;
      train_code  = makeIns(9'd40);
      tick();
    end
    rdy          = 1'b0;
    lookup_valid = 1'b0;
    train_valid  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      #1;
      checkOutput($sformatf("hold%0d_qcount", j), 32'(q_count), QH);
      if (j == 5) checkOutput("hold_ready", 32'(train_ready), 1);
      tick();
    end
    rdy         = 1'b1;
    train_valid = 1'b0;
    for (int j = 0; j <= QH; j++) begin
      #1;
      checkOutput($sformatf("resume%0d_qcount", j), 32'(q_count), QH - j);
      tick();
    end
    #1;
    checkOutput("resume_lookup40", 32'(lookup_taken), 1);

    // Reset mid-drain discards the queue and re-initialises the table
    lookup_valid = 1'b1;
    lookup_ins   = makeIns(9'd50);
    for (int k = 0; k < 3; k++) begin
      train_valid = 1'b1;
      train_taken = 1'b0;
      train_code  = makeIns(9'd50);
      tick();
    end
    #1;
    checkOutput("predrain_qcount", 32'(q_count), QH);
    rst         = 1'b1;
    train_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("drainrst_qcount", 32'(q_count), 0);
    checkOutput("drainrst_busy", 32'(busy), 1);
    checkOutput("drainrst_ready", 32'(train_ready), 0);
    checkOutput("drainrst_lookup", 32'(lookup_taken), 0);
    lookup_valid = 1'b0;
    waitSweep("resweep_cycles", 512);
    lookup_ins = makeIns(9'd20);
    #1;
    checkOutput("reinit_lookup20", 32'(lookup_taken), 0);
    lookup_ins = makeIns(9'd5);
    #1;
    checkOutput("reinit_lookup5", 32'(lookup_taken), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
- Owns the 2-bit branch history table (BHT) and schedules all accesses to it.
- Clears the table after reset with a multi-cycle sweep.
- Buffers ROB training events in a small FIFO and drains them one per cycle. A drain is deferred when it would collide with a same-index fetch lookup.
- Sits between the instruction fetcher's predictor front end (lookup) and the ROB commit path (training).

Parameters:
- SIZE, 9, BHT index width; table has 2**SIZE entries; index = ins[5+SIZE:6].
- QDEPTH, 4, training FIFO depth; power of two, >= 2.
- INIT_VAL, 1, 2-bit counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state is frozen.
- lookup_valid  in  1  fetcher presents an instruction this cycle.
- lookup_ins  in  32  instruction word being predicted.
- lookup_taken  out  1  predicted direction (counter bit 1); combinational.
- train_valid  in  1  ROB commits a branch outcome.
- train_taken  in  1  actual branch direction.
- train_code  in  32  committed branch instruction word.
- train_ready  out  1  FIFO can accept a training event.
- busy  out  1  init sweep in progress.
- q_count  out  $clog2(QDEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - FSM goes to INIT with sweep index 0.
  - FIFO is emptied: head=tail=0, q_count=0.
  - Outputs: busy=1, train_ready=0, lookup_taken=0.
- rdy=0:
  - No state changes: FSM, sweep index, FIFO pointers and table are all held.
  - A train event offered while rdy=0 is not accepted.
  - Combinational outputs still reflect the held state.
- INIT state:
  - Each rdy cycle writes INIT_VAL to entry[idx] and increments idx.
  - When idx == 2**SIZE-1 is written, the FSM moves to RUN on the next edge.
  - The sweep takes exactly 2**SIZE rdy cycles.
  - During INIT: busy=1, train_ready=0, lookup_taken=0, and no drains occur.
- RUN state: busy=0. The FSM stays in RUN until rst.
- rst asserted mid-sweep or mid-drain: restart INIT from idx 0 and discard all queued entries.
- Lookup:
  - lookup_taken = table[lookup_ins[5+SIZE:6]][1] when in RUN, else 0.
  - Pure read with zero latency; lookup_valid does not gate the read.
- Enqueue:
  - train_ready = (state==RUN) && (q_count < QDEPTH).
  - Push {hash(train_code), train_taken} when train_valid && train_ready && rdy.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Drain:
  - At most one pop per rdy cycle while the FIFO is non-empty, in RUN.
  - Pop updates table[head.idx] with a saturating counter: taken gives min(c+1,3); not-taken gives max(c-1,0).
- Conflict: without BHT_FWD_EN, the pop is stalled for the cycle when lookup_valid && lookup hash == head.idx. Lookup has priority.
- Simultaneous push and pop in the same cycle: q_count is unchanged and both pointers advance.
- Pointers wrap modulo QDEPTH.
- Entries are applied in arrival order. Two queued updates to the same index are applied on successive drain cycles.
- Table writes occur only at the clock edge. A lookup in the same cycle as a write sees the old value (unless forwarded, see below).

Optional Feature:
- Macro: BHT_FWD_EN.
- Defined:
  - Same-index conflicts never stall the drain; the pop proceeds.
  - lookup_taken returns bit 1 of the post-update counter value for that cycle.
  - The drain rate is therefore one per cycle whenever the FIFO is non-empty.
- Undefined:
  - Stall-on-conflict as described under Behaviour.
  - lookup_taken never sees an in-flight update.

Test Plan (SIZE=9, QDEPTH=4, INIT_VAL=1):
- Reset, hold rdy=1 -> busy=1 for exactly 512 cycles then 0; train_ready rises the same cycle; a lookup at any index gives lookup_taken=0, and table[*]=1.
- After init, push 2 taken events for index 5 (ins[14:6]=5) -> counter 1→2→3; lookup_taken at index 5 goes 0→1 after the first drain and stays 1.
- Push 5 events back-to-back with lookup_valid held on the head index (BHT_FWD_EN off) -> train_ready=0 after the 4th push; q_count stays 4; no drain until lookup_valid drops.
- Same stimulus with BHT_FWD_EN defined -> drain proceeds every cycle; lookup_taken shows the updated value in the drain cycle.
- Saturation: 3 not-taken events on a counter at 0, then 4 taken -> counter stays 0, then reaches 3 and stays 3.
- Toggle rdy=0 for 10 cycles mid-sweep (idx=100) and mid-drain (q_count=3) -> idx and q_count are unchanged; resumes exactly afterwards. Then rst at idx=300 -> busy and the sweep restart from 0; q_count=0.
